if_fetch_queue: RTL and testbench

- Parameterised successor to the single-register instruction fetch stage of the pipelined CPU.
- Generates sequential PCs and issues them to instruction memory over a request/grant interface that tolerates variable latency.
- Buffers returned instructions with their PCs in a QDEPTH-entry queue, then hands them to ID over a valid/ready handshake.
- Supports stall (PCWrite) and redirect from ID (PCSource/ID_PC); a redirect flushes both queued and in-flight instructions.

---
 rtl/if_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: credit-limited sequential PC requests, in-order response queue toward ID.
// Define IF_FETCH_STATS_EN to add saturating StatStall/StatRedirect/StatDrop counters.
module if_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               PCWrite,
    input  logic               PCSource,
    input  logic [ADDR_W-1:0]  ID_PC,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  PCtoInsMem,
    input  logic               IMemGnt,
    input  logic               IMemRValid,
    input  logic [INSTR_W-1:0] IMemRData,
    output logic               IFValid,
    input  logic               IFReady,
    output logic [INSTR_W-1:0] instructions,
    output logic [ADDR_W-1:0]  PCtoID
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0]        StatStall,
    output logic [31:0]        StatRedirect,
    output logic [31:0]        StatDrop
`endif
);

    localparam int unsigned       PTR_W      = $clog2(QDEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam int unsigned       STEP_LSB   = $clog2(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << STEP_LSB;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [CNT_W:0]    CREDITS    = (CNT_W+1)'(QDEPTH);

    typedef logic [CNT_W-1:0] cnt_t;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  q_pc    [QDEPTH];
    logic [INSTR_W-1:0] q_instr [QDEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    cnt_t               count;
    cnt_t               inflight;
    cnt_t               drop;
    cnt_t               drop_left;
    cnt_t               inflight_left;
    cnt_t               drop_next;
    cnt_t               inflight_next;
    logic [CNT_W:0]     credits_used;
    logic               accept;
    logic               resp_drop;
    logic               resp_live;
    logic               push;
    logic               pop;

    always_comb begin
        credits_used = {1'b0, count} + {1'b0, inflight} + {1'b0, drop};
        IMemReq      = PCWrite && (credits_used < CREDITS);
        PCtoInsMem   = fetch_pc;
        accept       = IMemReq && IMemGnt;
        redirect_pc  = ID_PC & ALIGN_MASK;
        IFValid      = (count != '0);
        instructions = IFValid ? q_instr[rd_ptr] : '0;
        PCtoID       = IFValid ? q_pc[rd_ptr] : '0;
        pop          = IFValid && IFReady;
    end

    // A response is charged to the pre-redirect drop/inflight first, so one
    // landing in a redirect cycle is retired and never reaches the queue.
    always_comb begin
        resp_drop     = IMemRValid && (drop != '0);
        resp_live     = IMemRValid && (drop == '0);
        drop_left     = drop - cnt_t'(resp_drop);
        inflight_left = inflight - cnt_t'(resp_live);
        push          = resp_live && !PCSource;
        if (PCSource) begin
            drop_next     = drop_left + inflight_left + cnt_t'(accept);
            inflight_next = '0;
        end else begin
            drop_next     = drop_left;
            inflight_next = inflight_left + cnt_t'(accept);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            drop     <= drop_next;
            if (PCSource) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + STEP;
                if (push) begin
                    resp_pc <= resp_pc + STEP;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= IMemRData;
        end
    end

`ifdef IF_FETCH_STATS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StatStall    <= '0;
            StatRedirect <= '0;
            StatDrop     <= '0;
        end else begin
            if (PCWrite && !IMemReq && (StatStall != '1)) StatStall <= StatStall + 32'd1;
            if (PCSource && (StatRedirect != '1)) StatRedirect <= StatRedirect + 32'd1;
            if (IMemRValid && !push && (StatDrop != '1)) StatDrop <= StatDrop + 32'd1;
        end
    end
`endif

    resp_has_owner: assert property (@(posedge Clk) disable iff (Reset)
        IMemRValid |-> ((inflight != '0) || (drop != '0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: in-order latency-configurable memory responder, inline checks.
module tb_if_fetch_queue;

    logic        Clk;
    logic        Reset;
    logic        PCWrite;
    logic        PCSource;
    logic [31:0] ID_PC;
    logic        IMemReq;
    logic [31:0] PCtoInsMem;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        IFValid;
    logic        IFReady;
    logic [31:0] instructions;
    logic [31:0] PCtoID;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned lat      = 1;
    logic        last_acc = 1'b0;
    logic [31:0] pend_addr [$];
    int unsigned pend_due  [$];

    if_fetch_queue #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .QDEPTH  (4),
        .RESET_PC(32'h0),
        .PC_STEP (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PCWrite     (PCWrite),
        .PCSource    (PCSource),
        .ID_PC       (ID_PC),
        .IMemReq     (IMemReq),
        .PCtoInsMem  (PCtoInsMem),
        .IMemGnt     (IMemGnt),
        .IMemRValid  (IMemRValid),
        .IMemRData   (IMemRData),
        .IFValid     (IFValid),
        .IFReady     (IFReady),
        .instructions(instructions),
        .PCtoID      (PCtoID)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // One clock: sample handshakes before the edge, update the memory model, drive next response at negedge.
    task automatic tick();
        logic        acc;
        logic        rsp;
        logic [31:0] a;
        #1;
        acc = IMemReq & IMemGnt;
        a   = PCtoInsMem;
        rsp = IMemRValid;
        @(posedge Clk);
        cyc++;
        last_acc = acc;
        if (rsp && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (acc) begin
            pend_addr.push_back(a);
            pend_due.push_back(cyc + lat - 1);
        end
        @(negedge Clk);
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            IMemRValid = 1'b1;
            IMemRData  = instr_of(pend_addr[0]);
        end else begin
            IMemRValid = 1'b0;
            IMemRData  = '0;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; PCWrite = 1'b0; PCSource = 1'b0; ID_PC = '0;
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = '0; IFReady = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; PCWrite = 1'b0; PCSource = 1'b0; ID_PC = '0;
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = '0; IFReady = 1'b0;
        @(negedge Clk);
        #1;
        n_checks++; if (IMemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", IMemReq); end
        n_checks++; if (IFValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", IFValid); end
        n_checks++; if (instructions !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instructions); end
        n_checks++; if (PCtoID !== 32'h0) begin n_fail++; $display("FAIL reset_pctoid: got %h expected 0", PCtoID); end
        n_checks++; if (PCtoInsMem !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", PCtoInsMem); end
        @(negedge Clk);
        Reset = 1'b0;
        cyc = 0;
        #1;
        n_checks++; if (PCtoInsMem !== 32'h0) begin n_fail++; $display("FAIL release_pc: got %h expected 0", PCtoInsMem); end
        n_checks++; if (IFValid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b expected 0", IFValid); end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1; PCWrite = 1'b1; IMemGnt = 1'b1; IFReady = 1'b1;
        #1;
        n_checks++; if (IMemReq !== 1'b1) begin n_fail++; $display("FAIL stream_req0: got %b expected 1", IMemReq); end
        n_checks++; if (PCtoInsMem !== 32'h0) begin n_fail++; $display("FAIL stream_pc0: got %h expected 0", PCtoInsMem); end
        for (int unsigned n = 1; n <= 8; n++) begin
            tick();
            n_checks++; if (PCtoInsMem !== 32'(4 * n)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", n, PCtoInsMem, 32'(4 * n)); end
            if (n == 1) begin
                n_checks++; if (IFValid !== 1'b0) begin n_fail++; $display("FAIL stream_valid[1]: got %b expected 0", IFValid); end
            end else begin
                n_checks++; if (IFValid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", n, IFValid); end
                n_checks++; if (PCtoID !== 32'(4 * (n - 2))) begin n_fail++; $display("FAIL stream_pctoid[%0d]: got %h expected %h", n, PCtoID, 32'(4 * (n - 2))); end
                n_checks++; if (instructions !== instr_of(32'(4 * (n - 2)))) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", n, instructions, instr_of(32'(4 * (n - 2)))); end
            end
        end
    endtask

    task automatic test_full_queue();
        int unsigned accepts = 0;
        do_reset();
        lat = 1; PCWrite = 1'b1; IMemGnt = 1'b1; IFReady = 1'b0;
        for (int unsigned n = 0; n < 10; n++) begin
            tick();
            if (last_acc) accepts++;
        end
        #1;
        n_checks++; if (accepts != 4) begin n_fail++; $display("FAIL full_accepts: got %0d expected 4", accepts); end
        n_checks++; if (IMemReq !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b expected 0", IMemReq); end
        n_checks++; if (IFValid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b expected 1", IFValid); end
        IFReady = 1'b1;
        for (int unsigned n = 0; n < 5; n++) begin
            #1;
            n_checks++; if (PCtoID !== 32'(4 * n)) begin n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", n, PCtoID, 32'(4 * n)); end
            n_checks++; if (instructions !== instr_of(32'(4 * n))) begin n_fail++; $display("FAIL full_instr[%0d]: got %h expected %h", n, instructions, instr_of(32'(4 * n))); end
            tick();
        end
    endtask

    task automatic test_redirect();
        int unsigned k = 0;
        do_reset();
        lat = 4; PCWrite = 1'b1; IMemGnt = 1'b1; IFReady = 1'b1;
        repeat (3) tick();
        PCSource = 1'b1; ID_PC = 32'h103; PCWrite = 1'b0;
        tick();
        PCSource = 1'b0; PCWrite = 1'b1;
        #1;
        n_checks++; if (PCtoInsMem !== 32'h100) begin n_fail++; $display("FAIL redir_pc: got %h expected 100", PCtoInsMem); end
        n_checks++; if (IFValid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b expected 0", IFValid); end
        while (!IFValid && k < 20) begin tick(); k++; end
        n_checks++; if (IFValid !== 1'b1) begin n_fail++; $display("FAIL redir_timeout: got valid %b expected 1 within 20 cycles", IFValid); end
        n_checks++; if (k != 5) begin n_fail++; $display("FAIL redir_latency: got %0d cycles expected 5", k); end
        n_checks++; if (PCtoID !== 32'h100) begin n_fail++; $display("FAIL redir_first: got %h expected 100", PCtoID); end
        n_checks++; if (instructions !== instr_of(32'h100)) begin n_fail++; $display("FAIL redir_instr: got %h expected %h", instructions, instr_of(32'h100)); end
    endtask

    task automatic test_redirect_edge();
        int unsigned k = 0;
        do_reset();
        lat = 3; PCWrite = 1'b1; IMemGnt = 1'b1; IFReady = 1'b1;
        repeat (3) tick();
        PCSource = 1'b1; ID_PC = 32'h200;
        #1;
        n_checks++; if (IMemReq !== 1'b1) begin n_fail++; $display("FAIL edge_req: got %b expected 1", IMemReq); end
        tick();
        PCSource = 1'b0;
        #1;
        n_checks++; if (IFValid !== 1'b0) begin n_fail++; $display("FAIL edge_valid: got %b expected 0", IFValid); end
        n_checks++; if (PCtoInsMem !== 32'h200) begin n_fail++; $display("FAIL edge_pc: got %h expected 200", PCtoInsMem); end
        while (!IFValid && k < 20) begin tick(); k++; end
        n_checks++; if (IFValid !== 1'b1) begin n_fail++; $display("FAIL edge_timeout: got valid %b expected 1 within 20 cycles", IFValid); end
        n_checks++; if (PCtoID !== 32'h200) begin n_fail++; $display("FAIL edge_first: got %h expected 200", PCtoID); end
    endtask

    task automatic test_back_to_back();
        int unsigned k = 0;
        do_reset();
        lat = 1; PCWrite = 1'b1; IMemGnt = 1'b1; IFReady = 1'b0;
        repeat (6) tick();
        IFReady = 1'b1; PCSource = 1'b1; ID_PC = 32'h40;
        tick();
        #1;
        n_checks++; if (IFValid !== 1'b0) begin n_fail++; $display("FAIL b2b_flush: got %b expected 0", IFValid); end
        n_checks++; if (PCtoInsMem !== 32'h40) begin n_fail++; $display("FAIL b2b_pc1: got %h expected 40", PCtoInsMem); end
        ID_PC = 32'h81;
        tick();
        PCSource = 1'b0;
        #1;
        n_checks++; if (PCtoInsMem !== 32'h80) begin n_fail++; $display("FAIL b2b_pc2: got %h expected 80", PCtoInsMem); end
        while (!IFValid && k < 20) begin tick(); k++; end
        n_checks++; if (PCtoID !== 32'h80) begin n_fail++; $display("FAIL b2b_first: got %h expected 80 (valid %b)", PCtoID, IFValid); end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 3; PCWrite = 1'b1; IMemGnt = 1'b1; IFReady = 1'b0;
        repeat (2) tick();
        PCWrite = 1'b0;
        for (int unsigned n = 0; n < 5; n++) begin
            tick();
            n_checks++; if (IMemReq !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 0", n, IMemReq); end
            n_checks++; if (PCtoInsMem !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected 8", n, PCtoInsMem); end
        end
        n_checks++; if (IFValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", IFValid); end
        n_checks++; if (PCtoID !== 32'h0) begin n_fail++; $display("FAIL stall_head0: got %h expected 0", PCtoID); end
        IFReady = 1'b1;
        tick();
        n_checks++; if (PCtoID !== 32'h4) begin n_fail++; $display("FAIL stall_head1: got %h expected 4", PCtoID); end
        n_checks++; if (instructions !== instr_of(32'h4)) begin n_fail++; $display("FAIL stall_instr1: got %h expected %h", instructions, instr_of(32'h4)); end
        tick();
        n_checks++; if (IFValid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b expected 0", IFValid); end
        n_checks++; if (PCtoInsMem !== 32'h8) begin n_fail++; $display("FAIL stall_pc_end: got %h expected 8", PCtoInsMem); end
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1; IMemGnt = 1'b1; IFReady = 1'b1; PCWrite = 1'b0;
        PCSource = 1'b1; ID_PC = 32'hFFFF_FFFF;
        tick();
        PCSource = 1'b0;
        #1;
        n_checks++; if (PCtoInsMem !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align: got %h expected fffffffc", PCtoInsMem); end
        PCWrite = 1'b1;
        tick();
        n_checks++; if (PCtoInsMem !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", PCtoInsMem); end
        tick();
        n_checks++; if (PCtoID !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_head0: got %h expected fffffffc", PCtoID); end
        tick();
        n_checks++; if (PCtoID !== 32'h0) begin n_fail++; $display("FAIL wrap_head1: got %h expected 0", PCtoID); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 1; PCWrite = 1'b1; IMemGnt = 1'b1; IFReady = 1'b0;
        repeat (6) tick();
        #1;
        n_checks++; if (IFValid !== 1'b1) begin n_fail++; $display("FAIL mid_full: got %b expected 1", IFValid); end
        Reset = 1'b1;
        #1;
        n_checks++; if (IFValid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", IFValid); end
        n_checks++; if (PCtoInsMem !== 32'h0) begin n_fail++; $display("FAIL mid_pc: got %h expected 0", PCtoInsMem); end
        n_checks++; if (PCtoID !== 32'h0) begin n_fail++; $display("FAIL mid_pctoid: got %h expected 0", PCtoID); end
        n_checks++; if (instructions !== 32'h0) begin n_fail++; $display("FAIL mid_instr: got %h expected 0", instructions); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_queue();
        test_redirect();
        test_redirect_edge();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
